// File: rtl/sipo_deser.sv
// Serial-in parallel-out deserializer with valid/ready output holding register and sticky overrun.
// Optional trailing even-parity bit per frame is enabled by defining SIPO_DESER_PARITY_EN.
module sipo_deser #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             sin_valid,
  input  logic             sin,
  input  logic             sync,
  output logic [WIDTH-1:0] dout,
  output logic             dout_valid,
  input  logic             dout_ready,
  output logic             overrun,
  input  logic             ovr_clr,
  output logic             parity_err
);

`ifdef SIPO_DESER_PARITY_EN
  localparam int FRAME = WIDTH + 1;
`else
  localparam int FRAME = WIDTH;
`endif
  localparam int CW = (FRAME > 1) ? $clog2(FRAME) : 1;
  localparam logic [CW-1:0] LAST = CW'(FRAME - 1);

  typedef enum logic {IDLE = 1'b0, SHIFT = 1'b1} state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [WIDTH-1:0] r_sreg;
  logic [CW-1:0]    r_cnt;
  logic [WIDTH-1:0] r_dout;
  logic             r_dout_valid;
  logic             r_overrun;

  logic [WIDTH-1:0] w_sreg_base;
  logic [CW-1:0]    w_cnt_base;
  logic [WIDTH-1:0] w_sreg_nxt;
  logic [CW-1:0]    w_cnt_nxt;
  logic [WIDTH-1:0] w_data;
  logic             w_complete;
  logic             w_load;
  logic             w_drop;

  // sync (or an idle frame) restarts assembly from an empty shift register
  always_comb begin
    if (sync || (r_state == IDLE)) begin
      w_sreg_base = '0;
      w_cnt_base  = '0;
    end else begin
      w_sreg_base = r_sreg;
      w_cnt_base  = r_cnt;
    end
  end

  always_comb begin
    w_sreg_nxt = sync ? '0 : r_sreg;
    w_cnt_nxt  = sync ? '0 : r_cnt;
    w_complete = 1'b0;
    if (sin_valid) begin
      w_sreg_nxt = {w_sreg_base[WIDTH-2:0], sin};
      if (w_cnt_base == LAST) begin
        w_cnt_nxt  = '0;
        w_complete = 1'b1;
      end else begin
        w_cnt_nxt  = w_cnt_base + CW'(1);
      end
    end else begin
      w_complete = 1'b0;
    end
  end

`ifdef SIPO_DESER_PARITY_EN
  // On the parity edge the data bits are already fully in sreg; sin is the parity bit
  assign w_data = w_sreg_base;
`else
  assign w_data = w_sreg_nxt;
`endif

  assign w_load = w_complete && (!r_dout_valid || dout_ready);
  assign w_drop = w_complete && r_dout_valid && !dout_ready;

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    if (w_cnt_nxt != '0) w_state_nxt = SHIFT; else w_state_nxt = IDLE;
      SHIFT:   if (w_cnt_nxt == '0) w_state_nxt = IDLE;  else w_state_nxt = SHIFT;
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
      r_sreg  <= '0;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_sreg  <= w_sreg_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_dout       <= '0;
      r_dout_valid <= 1'b0;
      r_overrun    <= 1'b0;
    end else begin
      if (w_load) begin
        r_dout       <= w_data;
        r_dout_valid <= 1'b1;
      end else if (r_dout_valid && dout_ready) begin
        r_dout_valid <= 1'b0;
      end else begin
        r_dout_valid <= r_dout_valid;
      end
      if (w_drop) begin
        r_overrun <= 1'b1;
      end else if (ovr_clr) begin
        r_overrun <= 1'b0;
      end else begin
        r_overrun <= r_overrun;
      end
    end
  end

`ifdef SIPO_DESER_PARITY_EN
  logic r_parity_err;

  // Parity status travels with the word held in dout
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_parity_err <= 1'b0;
    end else if (w_load) begin
      r_parity_err <= (^w_sreg_base) ^ sin;
    end else begin
      r_parity_err <= r_parity_err;
    end
  end

  assign parity_err = r_parity_err;
`else
  assign parity_err = 1'b0;
`endif

  assign dout       = r_dout;
  assign dout_valid = r_dout_valid;
  assign overrun    = r_overrun;

endmodule

// File: tb/tb_sipo_deser.sv
// Directed and randomized bench for sipo_deser against a frame-queue reference model.
module tb_sipo_deser;
  localparam int W = 4;
`ifdef SIPO_DESER_PARITY_EN
  localparam int FRAME = W + 1;
  localparam bit PAR = 1'b1;
`else
  localparam int FRAME = W;
  localparam bit PAR = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         sin_valid = 1'b0;
  logic         sin = 1'b0;
  logic         sync = 1'b0;
  logic [W-1:0] dout;
  logic         dout_valid;
  logic         dout_ready = 1'b0;
  logic         overrun;
  logic         ovr_clr = 1'b0;
  logic         parity_err;

  int n_cmp = 0;
  int n_err = 0;

  bit m_q[$];
  int m_dout = 0;
  bit m_valid = 1'b0;
  bit m_ovr = 1'b0;
  bit m_par = 1'b0;

  sipo_deser #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .sin_valid(sin_valid), .sin(sin), .sync(sync),
    .dout(dout), .dout_valid(dout_valid), .dout_ready(dout_ready),
    .overrun(overrun), .ovr_clr(ovr_clr), .parity_err(parity_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag);
    chk({tag, ".dout"}, 32'(dout), 32'(m_dout));
    chk({tag, ".dout_valid"}, 32'(dout_valid), 32'(m_valid));
    chk({tag, ".overrun"}, 32'(overrun), 32'(m_ovr));
    chk({tag, ".parity_err"}, 32'(parity_err), 32'(m_par));
  endtask

  // Reference behaviour of one clock edge, computed from the frame of bits received so far
  task automatic model_edge(input bit sv, input bit s, input bit sy, input bit rdy, input bit clr);
    bit done = 1'b0;
    bit dropped = 1'b0;
    int word = 0;
    bit par = 1'b0;
    if (sy) m_q.delete();
    if (sv) begin
      m_q.push_back(s);
      if (m_q.size() == FRAME) begin
        done = 1'b1;
        for (int i = 0; i < W; i++) word = word * 2 + int'(m_q[i]);
        for (int i = 0; i < FRAME; i++) par = par ^ m_q[i];
        m_q.delete();
      end
    end
    if (done) begin
      if (!m_valid || rdy) begin
        m_dout  = word;
        m_valid = 1'b1;
        m_par   = PAR ? par : 1'b0;
      end else begin
        dropped = 1'b1;
      end
    end else if (m_valid && rdy) begin
      m_valid = 1'b0;
    end
    if (dropped) m_ovr = 1'b1;
    else if (clr) m_ovr = 1'b0;
  endtask

  task automatic cyc(input bit sv, input bit s, input bit sy, input bit rdy, input bit clr);
    sin_valid  = sv;
    sin        = s;
    sync       = sy;
    dout_ready = rdy;
    ovr_clr    = clr;
    @(posedge clk);
    model_edge(sv, s, sy, rdy, clr);
    #1;
    check_all("cyc");
  endtask

  task automatic do_reset();
    rst = 1'b1;
    #2;
    m_q.delete();
    m_dout = 0; m_valid = 1'b0; m_ovr = 1'b0; m_par = 1'b0;
    check_all("reset");
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  task automatic send_word(input logic [W-1:0] wd, input bit rdy);
    logic [W-1:0] v;
    v = wd;
    for (int i = W - 1; i >= 0; i--) cyc(1'b1, v[i], 1'b0, rdy, 1'b0);
    if (PAR) cyc(1'b1, ^v, 1'b0, rdy, 1'b0);
  endtask

  initial begin
    sin_valid = 1'b0; sin = 1'b0; sync = 1'b0; dout_ready = 1'b0; ovr_clr = 1'b0;
    #1;
    do_reset();

    // consecutive bits, consumer stalled
    send_word(4'b1011, 1'b0);
    chk("req030.dout", 32'(dout), 32'h0000000b);
    chk("req030.valid", 32'(dout_valid), 32'h00000001);
    chk("req030.ovr", 32'(overrun), 32'h00000000);
    cyc(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);

    // gap cycles between accepted bits
    cyc(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    cyc(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    cyc(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    cyc(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    if (PAR) begin
      cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
      cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    end else begin
      cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    end
    chk("req031.dout", 32'(dout), 32'h0000000c);
    cyc(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);

    // overrun on a dropped word, then clear
    send_word(4'hA, 1'b0);
    send_word(4'h5, 1'b0);
    chk("req032.dout", 32'(dout), 32'h0000000a);
    chk("req032.ovr", 32'(overrun), 32'h00000001);
    cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    chk("req032.clr", 32'(overrun), 32'h00000000);
    cyc(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);

    // realign mid-frame with a bit on the same edge
    cyc(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    cyc(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    cyc(1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
    cyc(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    cyc(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    if (PAR) cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("req033.dout", 32'(dout), 32'h00000006);
    cyc(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);

    // reset mid-frame
    cyc(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    do_reset();
    cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    cyc(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    cyc(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    chk("req034.valid_before", 32'(dout_valid), 32'h00000000);
    send_word(4'b0111, 1'b0);
    cyc(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    do_reset();
    send_word(4'b0111, 1'b0);
    chk("req034.dout", 32'(dout), 32'h00000007);
    cyc(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);

`ifdef SIPO_DESER_PARITY_EN
    cyc(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    cyc(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    cyc(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    cyc(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    chk("req035.good", 32'(parity_err), 32'h00000000);
    cyc(1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
    cyc(1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
    cyc(1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
    cyc(1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
    cyc(1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
    chk("req035.bad", 32'(parity_err), 32'h00000001);
    cyc(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
`endif

    // randomized traffic with occasional sync, stalls, clears and one reset
    for (int i = 0; i < 600; i++) begin
      if (i == 300) do_reset();
      cyc($urandom_range(0, 3) != 0, 1'($urandom), $urandom_range(0, 15) == 0,
          $urandom_range(0, 2) == 0, $urandom_range(0, 15) == 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/sipo_deser.md
SIPO_DESER -- requirements
Module: sipo_deser

Interface
REQ-001 Parameter WIDTH, default 4: parallel word width in bits; legal range 2..32.
REQ-002 Port clk  input  1: single clock; all state SHALL update on its rising edge.
REQ-003 Port rst  input  1: reset; asynchronous, active-high.
REQ-004 Port sin_valid  input  1: qualifies sin; a bit SHALL be accepted only on edges where sin_valid=1.
REQ-005 Port sin  input  1: serial data bit, MSB of each word first.
REQ-006 Port sync  input  1: frame realign; discards any partial word.
REQ-007 Port dout  output  WIDTH: assembled parallel word.
REQ-008 Port dout_valid  output  1: dout holds an unconsumed word.
REQ-009 Port dout_ready  input  1: consumer accepts dout when dout_valid=1 and dout_ready=1 on an edge.
REQ-010 Port overrun  output  1: sticky flag, a completed word was dropped.
REQ-011 Port ovr_clr  input  1: synchronous clear of overrun.
REQ-012 Port parity_err  output  1: parity result for the word in dout (see Configuration).

Function
REQ-013 Block SHALL contain a shift register sreg, a bit counter cnt (0..FRAME-1), a holding register dout and a two-state FSM: IDLE (cnt=0, no partial word) and SHIFT (cnt>0).
REQ-014 FRAME SHALL equal WIDTH without parity, WIDTH+1 with parity.
REQ-015 On an accepted bit, sreg <= {sreg[WIDTH-2:0], sin}; cnt increments; IDLE->SHIFT on first bit.
REQ-016 On the edge accepting bit FRAME-1, cnt SHALL wrap to 0, FSM SHALL return to IDLE, and the word SHALL complete.
REQ-017 Word completion: dout <= the WIDTH data bits (MSB first received = dout[WIDTH-1]); dout_valid=1 visible after that same edge (zero added latency).
REQ-018 dout and dout_valid SHALL hold stable while dout_valid=1 and dout_ready=0.
REQ-019 Handshake with no completion on the same edge: dout_valid SHALL clear; dout keeps its value.
REQ-020 Completion on an edge with dout_valid=1 and dout_ready=1: new word SHALL load, dout_valid stays 1, overrun unchanged.
REQ-021 Completion on an edge with dout_valid=1 and dout_ready=0: new word SHALL be dropped, dout unchanged, overrun <= 1.
REQ-022 sync=1: cnt <= 0 and partial sreg discarded; if sin_valid=1 on the same edge, sin SHALL be taken as bit 0 of a new frame (cnt <= 1); dout/dout_valid unaffected.
REQ-023 ovr_clr=1 SHALL clear overrun unless a drop occurs on the same edge, in which case overrun SHALL stay 1.
REQ-024 sin_valid=0 SHALL leave sreg, cnt and FSM unchanged.

Reset
REQ-025 rst=1 SHALL asynchronously force sreg=0, cnt=0, FSM=IDLE, dout=0, dout_valid=0, overrun=0, parity_err=0.
REQ-026 Reset mid-frame SHALL discard the partial word; the first accepted bit after release is bit 0 of a new frame.

Configuration
REQ-027 Macro SIPO_DESER_PARITY_EN SHALL enable a trailing even-parity bit per frame.
REQ-028 With macro: frame = WIDTH data bits + 1 parity bit; parity_err <= (XOR of data bits XOR parity bit), loaded with dout at completion, handled per REQ-018..021.
REQ-029 Without macro: frame = WIDTH bits; parity_err SHALL be constant 0; no parity logic present.

Verification (WIDTH=4)
REQ-030 Bits 1,0,1,1 with sin_valid=1 on consecutive edges, dout_ready=0 -> dout=4'b1011, dout_valid=1 after 4th edge, overrun=0.
REQ-031 Bits 1,1,0,0 with sin_valid gap cycles between bits -> dout=4'b1100; gaps add no bits.
REQ-032 Word 4'hA held unconsumed, second word 4'h5 completes with dout_ready=0 -> dout stays 4'hA, overrun=1; ovr_clr pulse -> overrun=0.
REQ-033 Two bits sent, then sync=1 with sin_valid=1, sin=0, then bits 1,1,0 -> dout=4'b0110.
REQ-034 rst asserted after 2 bits, released, 4 bits 0,1,1,1 sent -> dout=4'b0111, all flags 0 before completion.
REQ-035 With SIPO_DESER_PARITY_EN: frame 1,0,1,1,parity 1 -> parity_err=0; same data with parity 0 -> parity_err=1.
